// File: rtl/k423_if_fetch_pkg.sv
// Shared types and constants for the k423 instruction-fetch unit.
// Optional access-fault support is enabled by defining K423_IF_ACCESS_FAULT_EN.
package k423_if_fetch_pkg;

  localparam int CORE_XLEN   = 32;
  localparam int CORE_INST_W = 32;

  localparam logic [CORE_XLEN-1:0] IF_RST_PC     = 32'h8000_0000;
  localparam int                   IF_FIFO_DEPTH = 2;

`ifdef K423_IF_ACCESS_FAULT_EN
  localparam int IF_ENTRY_W = CORE_XLEN + CORE_INST_W + 1;

  typedef enum logic [1:0] {
    IF_ST_BOOT = 2'd0,
    IF_ST_RUN  = 2'd1,
    IF_ST_HALT = 2'd2
  } if_state_e;

  typedef struct packed {
    logic [CORE_XLEN-1:0]   pc;
    logic [CORE_INST_W-1:0] inst;
    logic                   err;
  } if_entry_t;
`else
  localparam int IF_ENTRY_W = CORE_XLEN + CORE_INST_W;

  typedef enum logic [1:0] {
    IF_ST_BOOT = 2'd0,
    IF_ST_RUN  = 2'd1
  } if_state_e;

  typedef struct packed {
    logic [CORE_XLEN-1:0]   pc;
    logic [CORE_INST_W-1:0] inst;
  } if_entry_t;
`endif

  // Fetch addresses are always word aligned; the low two bits are forced to zero.
  function automatic logic [CORE_XLEN-1:0] if_align_pc(input logic [CORE_XLEN-1:0] pc);
    return pc & ~CORE_XLEN'(3);
  endfunction

  function automatic logic [CORE_XLEN-1:0] if_next_pc(input logic [CORE_XLEN-1:0] pc);
    return pc + CORE_XLEN'(4);
  endfunction

endpackage

// File: rtl/k423_if_fetch_if.sv
// Bus bundle between the fetch unit, instruction memory and the ID stage.
// The error/fault pair exists only when K423_IF_ACCESS_FAULT_EN is defined.
interface k423_if_fetch_if;
  import k423_if_fetch_pkg::*;

  logic                   imem_req_vld_o;
  logic                   imem_req_rdy_i;
  logic [CORE_XLEN-1:0]   imem_req_addr_o;
  logic                   imem_rsp_vld_i;
  logic [CORE_INST_W-1:0] imem_rsp_data_i;
`ifdef K423_IF_ACCESS_FAULT_EN
  logic                   imem_rsp_err_i;
  logic                   if_fault_o;
`endif
  logic                   if_vld_o;
  logic                   id_rdy_i;
  logic [CORE_INST_W-1:0] if_inst_o;
  logic [CORE_XLEN-1:0]   if_pc_o;

  // Names are from the fetch unit's point of view, which is the master side.
  modport master (
    input  imem_req_rdy_i, imem_rsp_vld_i, imem_rsp_data_i, id_rdy_i,
`ifdef K423_IF_ACCESS_FAULT_EN
    input  imem_rsp_err_i,
    output if_fault_o,
`endif
    output imem_req_vld_o, imem_req_addr_o, if_vld_o, if_inst_o, if_pc_o
  );

  modport slave (
    output imem_req_rdy_i, imem_rsp_vld_i, imem_rsp_data_i, id_rdy_i,
`ifdef K423_IF_ACCESS_FAULT_EN
    output imem_rsp_err_i,
    input  if_fault_o,
`endif
    input  imem_req_vld_o, imem_req_addr_o, if_vld_o, if_inst_o, if_pc_o
  );

endinterface

// File: rtl/k423_if_fifo.sv
// Small synchronous FIFO holding fetched {pc, inst[, err]} entries for the ID stage.
// DEPTH must be a power of two and at least 2; flush takes priority over push and pop.
module k423_if_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o,
  output logic                       full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign head_o  = mem_q[rptr_q];

  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= push_data_i;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (do_pop) begin
        rptr_q <= rptr_q + AW'(1);
      end
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/k423_if_fetch.sv
// Instruction-fetch unit: owns the fetch PC, issues credit-limited word requests,
// buffers responses for ID and drops stale responses after a redirect.
// Access-fault tracking and the HALT state are enabled by K423_IF_ACCESS_FAULT_EN.
module k423_if_fetch
  import k423_if_fetch_pkg::*;
#(
  parameter logic [CORE_XLEN-1:0] RST_PC     = IF_RST_PC,
  parameter int                   FIFO_DEPTH = IF_FIFO_DEPTH
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 redirect_vld_i,
  input  logic [CORE_XLEN-1:0] redirect_pc_i,
  k423_if_fetch_if.master      bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  if_state_e            state_q;
  logic [CORE_XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CORE_XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]        inflight_q, inflight_d;
  logic [CW-1:0]        discard_q, discard_d;

  logic [CW-1:0]        fifo_cnt;
  logic                 fifo_empty;
  logic                 fifo_full;
  if_entry_t            push_entry;
  if_entry_t            head_entry;

  logic [CW:0]          credit_used;
  logic                 req_vld;
  logic                 req_fire;
  logic                 rsp_take;
  logic                 rsp_keep;
  logic                 push;
  logic                 pop;
  logic [CORE_XLEN-1:0] redirect_pc;

  assign redirect_pc = if_align_pc(redirect_pc_i);

  // Live requests (not marked for discard) plus buffered entries must stay below depth.
  assign credit_used = {1'b0, inflight_q - discard_q} + {1'b0, fifo_cnt};
  assign req_vld     = (state_q != IF_ST_BOOT) & (state_q == IF_ST_RUN) & ~redirect_vld_i
                     & (credit_used < (CW+1)'(FIFO_DEPTH));
  assign req_fire    = req_vld & bus.imem_req_rdy_i;

  // Responses during BOOT belong to a transaction from before reset and are ignored.
  assign rsp_take = bus.imem_rsp_vld_i & (state_q != IF_ST_BOOT);
  assign rsp_keep = rsp_take & ~redirect_vld_i & (discard_q == '0);
  assign pop      = ~fifo_empty & bus.id_rdy_i;
  assign push     = rsp_keep & (~fifo_full | pop);

  always_comb begin
    push_entry      = '0;
    push_entry.pc   = rsp_pc_q;
    push_entry.inst = bus.imem_rsp_data_i;
`ifdef K423_IF_ACCESS_FAULT_EN
    push_entry.err  = bus.imem_rsp_err_i;
`endif
  end

  // A redirect restarts both PCs and marks every still-outstanding response as stale.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_take);
    discard_d  = discard_q;
    if (redirect_vld_i) begin
      fetch_pc_d = redirect_pc;
      rsp_pc_d   = redirect_pc;
      discard_d  = inflight_q - CW'(rsp_take);
    end else begin
      if (req_fire) begin
        fetch_pc_d = if_next_pc(fetch_pc_q);
      end
      if (push) begin
        rsp_pc_d = if_next_pc(rsp_pc_q);
      end
      if (rsp_take && (discard_q != '0)) begin
        discard_d = discard_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fetch_pc_q <= RST_PC;
      rsp_pc_q   <= RST_PC;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  // BOOT lasts exactly one cycle even when a redirect arrives during it.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IF_ST_BOOT;
    end else begin
      case (state_q)
        IF_ST_BOOT: state_q <= IF_ST_RUN;
`ifdef K423_IF_ACCESS_FAULT_EN
        IF_ST_RUN:  state_q <= (push && push_entry.err) ? IF_ST_HALT : IF_ST_RUN;
        IF_ST_HALT: state_q <= redirect_vld_i ? IF_ST_RUN : IF_ST_HALT;
`else
        IF_ST_RUN:  state_q <= IF_ST_RUN;
`endif
        default:    state_q <= IF_ST_BOOT;
      endcase
    end
  end

  k423_if_fifo #(
    .WIDTH (IF_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (redirect_vld_i),
    .head_o      (head_entry),
    .count_o     (fifo_cnt),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  assign bus.imem_req_vld_o  = req_vld;
  assign bus.imem_req_addr_o = fetch_pc_q;
  assign bus.if_vld_o        = ~fifo_empty;
  assign bus.if_inst_o       = head_entry.inst;
  assign bus.if_pc_o         = head_entry.pc;
`ifdef K423_IF_ACCESS_FAULT_EN
  assign bus.if_fault_o      = head_entry.err & ~fifo_empty;
`endif

endmodule

// File: tb/tb_k423_if_fetch.sv
// Self-checking bench for k423_if_fetch: in-order memory model, stream-level
// reference model of the PC sequence, directed corner cases and a random phase.
module tb_k423_if_fetch;
  import k423_if_fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam int          DEPTH  = 2;

  typedef struct {
    logic [31:0] addr;
    int          due;
    logic        err;
  } memTxn_t;

  typedef struct {
    logic [31:0] redirPc;
    logic [31:0] expAddr0;
    logic [31:0] expAddr1;
  } wrapVec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_vld = 1'b0;
  logic [31:0] redirect_pc = '0;

  k423_if_fetch_if bus ();

  k423_if_fetch #(
    .RST_PC     (RST_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .redirect_vld_i (redirect_vld),
    .redirect_pc_i  (redirect_pc),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cycle = 0;
  int rdyPct = 100;
  int latMin = 1;
  int latMax = 1;
  int errIndex = 0;
  int acceptCount = 0;
  int delivered = 0;
  bit idRdy = 1'b0;
  bit doRedirect = 1'b0;
  bit forceRsp = 1'b0;
  logic [31:0] redirTarget = '0;

  memTxn_t     memQ[$];
  logic [31:0] reqLog[$];

  bit          sReqVld, sReqFire, sIfVld, sIdFire;
  logic [31:0] sReqAddr, sIfPc, sIfInst, lastIdPc;
`ifdef K423_IF_ACCESS_FAULT_EN
  bit          sFault;
`endif

  // Reference view: the request stream and the ID stream are each a +4 sequence
  // restarted at the aligned target of every redirect.
  logic [31:0] expReqAddr;
  logic [31:0] expIdPc;
  int          issued;
  int          consumed;

  function automatic logic [31:0] memData(input logic [31:0] a);
    return (a ^ 32'h3C5A_96E1) + {a[15:0], a[31:16]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // One clock cycle: drive at the negedge, sample 1ns later, retire at the posedge.
  task automatic applyStimulus();
    memTxn_t head;
    bus.imem_req_rdy_i = ($urandom_range(99) < rdyPct);
    bus.id_rdy_i       = idRdy;
    redirect_vld       = doRedirect;
    redirect_pc        = redirTarget;
`ifdef K423_IF_ACCESS_FAULT_EN
    bus.imem_rsp_err_i = 1'b0;
`endif
    if (forceRsp) begin
      bus.imem_rsp_vld_i  = 1'b1;
      bus.imem_rsp_data_i = 32'hDEAD_BEEF;
    end else if (memQ.size() != 0 && memQ[0].due <= cycle) begin
      head = memQ.pop_front();
      bus.imem_rsp_vld_i  = 1'b1;
      bus.imem_rsp_data_i = memData(head.addr);
`ifdef K423_IF_ACCESS_FAULT_EN
      bus.imem_rsp_err_i  = head.err;
`endif
    end else begin
      bus.imem_rsp_vld_i  = 1'b0;
      bus.imem_rsp_data_i = '0;
    end
    #1;
    sReqVld  = bus.imem_req_vld_o;
    sReqFire = bus.imem_req_vld_o & bus.imem_req_rdy_i;
    sReqAddr = bus.imem_req_addr_o;
    sIfVld   = bus.if_vld_o;
    sIdFire  = bus.if_vld_o & bus.id_rdy_i;
    sIfPc    = bus.if_pc_o;
    sIfInst  = bus.if_inst_o;
`ifdef K423_IF_ACCESS_FAULT_EN
    sFault   = bus.if_fault_o;
`endif
    if (doRedirect) checkOutput("no req in redirect cycle", sReqVld, 0);
    if (sReqFire) begin
      checkOutput("req addr", sReqAddr, expReqAddr);
      checkOutput("credit bound", (issued - consumed) < DEPTH, 1);
      expReqAddr = expReqAddr + 32'd4;
      issued++;
      acceptCount++;
      reqLog.push_back(sReqAddr);
    end
    if (sIdFire) begin
      checkOutput("id pc", sIfPc, expIdPc);
      checkOutput("id inst", sIfInst, memData(sIfPc));
      expIdPc = expIdPc + 32'd4;
      consumed++;
      delivered++;
      lastIdPc = sIfPc;
    end
    if (doRedirect) begin
      expReqAddr = redirTarget & 32'hFFFF_FFFC;
      expIdPc    = redirTarget & 32'hFFFF_FFFC;
      issued     = 0;
      consumed   = 0;
    end
    @(posedge clk);
    if (sReqFire) begin
      memQ.push_back('{addr: sReqAddr,
                       due:  cycle + latMin + $urandom_range(latMax - latMin),
                       err:  (errIndex != 0) && (acceptCount == errIndex)});
    end
    cycle++;
    @(negedge clk);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    memQ.delete();
    reqLog.delete();
    idRdy = 1'b0; doRedirect = 1'b0; forceRsp = 1'b0; errIndex = 0;
    bus.imem_req_rdy_i = 1'b0; bus.imem_rsp_vld_i = 1'b0; bus.imem_rsp_data_i = '0;
    bus.id_rdy_i = 1'b0; redirect_vld = 1'b0;
`ifdef K423_IF_ACCESS_FAULT_EN
    bus.imem_rsp_err_i = 1'b0;
`endif
    #1;
    checkOutput("reset req_vld", bus.imem_req_vld_o, 0);
    checkOutput("reset req_addr", bus.imem_req_addr_o, RST_PC);
    checkOutput("reset if_vld", bus.if_vld_o, 0);
    checkOutput("reset if_pc", bus.if_pc_o, 0);
    checkOutput("reset if_inst", bus.if_inst_o, 0);
`ifdef K423_IF_ACCESS_FAULT_EN
    checkOutput("reset if_fault", bus.if_fault_o, 0);
`endif
    @(negedge clk);
    @(negedge clk);
    expReqAddr = RST_PC; expIdPc = RST_PC;
    issued = 0; consumed = 0; acceptCount = 0;
    rst_n = 1'b1;
  endtask

  task automatic runUntilDelivered(input int target, input int budget, input string name);
    int n = 0;
    while (delivered < target && n < budget) begin
      applyStimulus();
      n++;
    end
    checkOutput(name, delivered >= target, 1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    wrapVec_t vecs[5];
    int       n;
    int       mark;
    bit       sawPc4;

    vecs[0] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[1] = '{32'h8000_0103, 32'h8000_0100, 32'h8000_0104};
    vecs[2] = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0004};
    vecs[3] = '{32'h1234_567A, 32'h1234_5678, 32'h1234_567C};
    vecs[4] = '{32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFFC};

    @(negedge clk);

    // Startup latency with an always-ready, 1-cycle memory.
    doReset();
    rdyPct = 100; latMin = 1; latMax = 1; idRdy = 1'b1;
    applyStimulus(); checkOutput("boot no req", sReqVld, 0);
    applyStimulus(); checkOutput("first req vld", sReqVld, 1);
    checkOutput("first req addr", sReqAddr, RST_PC);
    applyStimulus(); checkOutput("if_vld before push", sIfVld, 0);
    applyStimulus(); checkOutput("first if_vld", sIfVld, 1);
    checkOutput("first if_pc", sIfPc, RST_PC);
    applyStimulus(); checkOutput("second if_vld", sIfVld, 1);
    checkOutput("second if_pc", sIfPc, RST_PC + 32'd4);
    runUntilDelivered(delivered + 4, 30, "startup stream progress");

    // ID stalled: credit caps outstanding work at the FIFO depth.
    doReset();
    rdyPct = 100; latMin = 1; latMax = 1; idRdy = 1'b0;
    for (int i = 0; i < 12; i++) applyStimulus();
    checkOutput("stalled accept count", acceptCount, 2);
    checkOutput("stalled req_vld", sReqVld, 0);
    checkOutput("stalled if_vld", sIfVld, 1);
    checkOutput("stalled head pc", sIfPc, RST_PC);
    idRdy = 1'b1;
    runUntilDelivered(delivered + 6, 40, "resume after stall");

    // Redirect with two requests in flight and slow memory.
    doReset();
    rdyPct = 100; latMin = 3; latMax = 3; idRdy = 1'b1;
    applyStimulus(); applyStimulus(); applyStimulus();
    checkOutput("two in flight", acceptCount, 2);
    doRedirect = 1'b1; redirTarget = 32'h8000_0100;
    applyStimulus();
    doRedirect = 1'b0;
    runUntilDelivered(delivered + 1, 30, "post-redirect delivery");
    checkOutput("post-redirect first pc", lastIdPc, 32'h8000_0100);

    // Redirect coinciding with a response and an ID handshake.
    doReset();
    rdyPct = 100; latMin = 1; latMax = 1; idRdy = 1'b0;
    applyStimulus(); applyStimulus(); applyStimulus();
    idRdy = 1'b1; doRedirect = 1'b1; redirTarget = 32'h8000_0300;
    applyStimulus();
    checkOutput("handshake in redirect cycle", sIdFire, 1);
    checkOutput("response in redirect cycle", bus.imem_rsp_vld_i, 1);
    doRedirect = 1'b0;
    applyStimulus();
    checkOutput("fifo empty after redirect", sIfVld, 0);
    runUntilDelivered(delivered + 3, 30, "delivery after redirect+rsp");

    // Redirect target alignment and address wrap, table driven.
    latMin = 1; latMax = 1; rdyPct = 100; idRdy = 1'b1;
    foreach (vecs[v]) begin
      doRedirect = 1'b1; redirTarget = vecs[v].redirPc;
      applyStimulus();
      doRedirect = 1'b0;
      reqLog.delete();
      n = 0;
      while (reqLog.size() < 2 && n < 20) begin
        applyStimulus();
        n++;
      end
      checkOutput("wrap vector req count", reqLog.size() >= 2, 1);
      if (reqLog.size() >= 2) begin
        checkOutput("wrap vector addr0", reqLog[0], vecs[v].expAddr0);
        checkOutput("wrap vector addr1", reqLog[1], vecs[v].expAddr1);
      end
    end

    // Reset mid-operation, then a spurious response during BOOT must be ignored.
    for (int i = 0; i < 5; i++) applyStimulus();
    doReset();
    rdyPct = 100; latMin = 1; latMax = 1; idRdy = 1'b1;
    forceRsp = 1'b1;
    applyStimulus();
    forceRsp = 1'b0;
    applyStimulus();
    checkOutput("boot response ignored", sIfVld, 0);
    runUntilDelivered(delivered + 3, 30, "delivery after mid-run reset");

`ifdef K423_IF_ACCESS_FAULT_EN
    // Access fault on the second response halts fetch until a redirect.
    doReset();
    rdyPct = 100; latMin = 1; latMax = 1; idRdy = 1'b1; errIndex = 2;
    sawPc4 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus();
      if (sIdFire) begin
        if (sIfPc == RST_PC + 32'd4) begin
          sawPc4 = 1'b1;
          checkOutput("fault on pc 4", sFault, 1);
        end else begin
          checkOutput("no fault on good pc", sFault, 0);
        end
      end
    end
    checkOutput("faulting entry delivered", sawPc4, 1);
    checkOutput("halt accept count", acceptCount, 2);
    checkOutput("halt req_vld", sReqVld, 0);
    errIndex = 0;
    doRedirect = 1'b1; redirTarget = 32'h8000_0200;
    applyStimulus();
    doRedirect = 1'b0;
    reqLog.delete();
    n = 0;
    while (reqLog.size() < 1 && n < 10) begin
      applyStimulus();
      n++;
    end
    checkOutput("resume after halt", reqLog.size() >= 1, 1);
    if (reqLog.size() >= 1) checkOutput("resume addr", reqLog[0], 32'h8000_0200);
`endif

    // Random traffic against the stream-level model.
    doReset();
    rdyPct = 75; latMin = 1; latMax = 2;
    mark = delivered;
    for (int i = 0; i < 1500; i++) begin
      idRdy = ($urandom_range(99) < 70);
      doRedirect = ($urandom_range(99) < 4);
      case ($urandom_range(3))
        0: redirTarget = $urandom;
        1: redirTarget = 32'hFFFF_FFF0 | 32'($urandom_range(15));
        2: redirTarget = RST_PC + 32'($urandom_range(255) << 2);
        default: redirTarget = $urandom & 32'hFFFF_FFFC;
      endcase
      applyStimulus();
    end
    doRedirect = 1'b0;
    checkOutput("random phase throughput", (delivered - mark) > 200, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
